mux_skid_stage: RTL and testbench
=================================

MUX_SKID_STAGE -- requirements
Module: mux_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width of every input and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4: number of selectable inputs, legal range 2..16.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port sel  input  max(1,$clog2(NUM_IN))  input select, sampled with in_valid.
REQ-007 The block SHALL have port in_valid  input  1  upstream offers a transfer.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a transfer this cycle.
REQ-009 The block SHALL have port out_data  output  WIDTH  head-of-stage data.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a valid transfer.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 The block SHALL have port flush  input  1  discard all held and incoming data.
REQ-013 The block SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 An input transfer SHALL occur in any cycle with in_valid=1, in_ready=1 and flush=0.
REQ-015 An output transfer SHALL occur in any cycle with out_valid=1 and out_ready=1.
REQ-016 The selected word SHALL be input sel; any sel>=NUM_IN SHALL select input NUM_IN-1.
REQ-017 The selection SHALL be captured at the input transfer; later changes to sel or in_data SHALL NOT alter held data.
REQ-018 Latency SHALL be one cycle: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N.
REQ-019 Sustained throughput SHALL be one transfer per cycle whenever out_ready=1.
REQ-020 The state machine SHALL have states EMPTY (0 held), BUSY (1 held, in main register) and FULL (main plus skid register).
REQ-021 In EMPTY, an input transfer SHALL go to BUSY; otherwise the state SHALL stay EMPTY.
REQ-022 In BUSY:
- input only -> FULL, new word into skid;
- output only -> EMPTY;
- input and output together -> stay BUSY, new word into main;
- neither -> stay BUSY.
REQ-023 In FULL:
- output transfer -> BUSY, skid word moves into main;
- no output transfer -> stay FULL.
REQ-024 in_ready SHALL be 1 exactly when the state is not FULL, driven from a register with no combinational path from out_ready.
REQ-025 out_valid SHALL be 1 exactly in BUSY and FULL; occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-026 Output order SHALL equal acceptance order; no word SHALL be dropped or duplicated except by flush or RST.
REQ-027 flush=1 SHALL force EMPTY at the next edge in every state, discarding held words and any concurrent in_valid word.
REQ-028 RST SHALL take priority over flush and over all transfers.
REQ-029 out_data SHALL hold its last value while out_valid=0; it SHALL be 0 only after reset.

Reset
REQ-030 While RST=1 at a rising edge, the state SHALL become EMPTY, with out_valid=0, out_data=0, occupancy=0 and in_ready=1 after that edge.
REQ-031 A reset arriving mid-operation (BUSY or FULL) SHALL discard held data with no output transfer after the edge.

Structure
REQ-032 Package otter_mux_pkg SHALL hold the state enum typedef (EMPTY, BUSY, FULL) and the select-width helper constant function.
REQ-033 The N:1 selection SHALL be a combinational sub-module mux_nto1, parametrised by WIDTH and NUM_IN, that applies the clamp in REQ-016.
REQ-034 mux_skid_stage SHALL contain only the main register, the skid register, the state register and the next-state logic.

Verification (WIDTH=32, NUM_IN=4)
REQ-035 Inputs 0x11,0x22,0x33,0x44, sel=2, one in_valid pulse, out_ready=1 -> the next cycle shows out_data=0x33 and out_valid=1 for one cycle, with occupancy 0->1->0.
REQ-036 The bench SHALL check the sel clamp with NUM_IN=3 and sel=3: the stage shall capture input 2.
REQ-037 Stream 0xA0..0xA7, one per cycle, with out_ready low on cycles 3-4 -> in_ready drops after FULL, all 8 words exit in order with none lost, and occupancy never exceeds 2.
REQ-038 In FULL, flush=1 with in_valid=1 -> next cycle EMPTY, out_valid=0, in_ready=1, and the concurrent word never appears.
REQ-039 In BUSY, RST=1 for one cycle -> out_valid=0 and out_data=0 after that edge, then the next accepted word 0x5A appears normally.
REQ-040 In BUSY, in_valid=1 and out_ready=1 on every cycle for 100 cycles -> occupancy stays 1 and output matches input delayed by 1 cycle.

Source files
------------

// File: rtl/otter_mux_pkg.sv
// -----------------------------------------------------------------------------
// otter_mux_pkg
// Shared types and helpers for the mux/skid stage.
//   state_e   : occupancy state of the two-entry stage (EMPTY / BUSY / FULL)
//   sel_width : width of a select bus for n inputs, never less than one bit
// -----------------------------------------------------------------------------
package otter_mux_pkg;

    // The encoding matches the number of held words, so the state value
    // can also serve as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    // max(1, clog2(n)): a two-input mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : otter_mux_pkg

// File: rtl/mux_nto1.sv
// -----------------------------------------------------------------------------
// mux_nto1
// Combinational N:1 word selector with out-of-range clamping.
//   in_data  : NUM_IN packed words, word k at [k*WIDTH +: WIDTH]
//   sel      : word index; any value >= NUM_IN picks word NUM_IN-1
//   out_data : selected word
// -----------------------------------------------------------------------------
module mux_nto1
    import otter_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0]       in_data,
    input  logic [sel_width(NUM_IN)-1:0]  sel,
    output logic [WIDTH-1:0]              out_data
);

    localparam int SEL_W = sel_width(NUM_IN);

    // The default of the last word doubles as the clamp: an out-of-range
    // select matches no index in the loop and falls through to it.
    // NOTE: assigning every always_comb output before any condition is what
    // keeps the block purely combinational; a missed path would infer a latch.
    always_comb begin
        out_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_IN - 1; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_nto1

// File: rtl/mux_skid_stage.sv
// -----------------------------------------------------------------------------
// mux_skid_stage
// Selects one of NUM_IN input words and passes it through a two-entry
// valid/ready stage (main register + skid register), one cycle of latency,
// full throughput, with in_ready fully registered.
//   CLK, RST   : clock, synchronous active-high reset
//   in_data    : NUM_IN packed input words
//   sel        : input select, captured with the input transfer
//   in_valid   : upstream offers a word
//   in_ready   : stage can accept a word (registered)
//   out_data   : head word (holds its value while out_valid is low)
//   out_valid  : out_data is a valid transfer
//   out_ready  : downstream accepts out_data
//   flush      : discard held and incoming words
//   occupancy  : number of held words, 0..2
// -----------------------------------------------------------------------------
module mux_skid_stage
    import otter_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_IN*WIDTH-1:0]       in_data,
    input  logic [sel_width(NUM_IN)-1:0]  sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [1:0]                    occupancy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q,  main_d;
    logic [WIDTH-1:0]   skid_q,  skid_d;
    logic               in_ready_q;
    logic [WIDTH-1:0]   sel_word;
    logic               in_xfer;
    logic               out_xfer;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (sel_word)
    );

    assign in_xfer  = in_valid && in_ready_q && !flush;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    main_d  = sel_word;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = sel_word;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = sel_word;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush empties the stage but leaves the data registers untouched so
        // out_data keeps showing the last head word while out_valid is low.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, whatever the order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered from the next state: no path from out_ready.
            in_ready_q <= (state_d != FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;

endmodule : mux_skid_stage

// File: tb/tb_mux_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_mux_skid_stage
// Self-checking bench for mux_skid_stage (WIDTH=32, NUM_IN=4) plus a second
// instance with NUM_IN=3 for the select clamp.
// -----------------------------------------------------------------------------
module tb_mux_skid_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         flush;
    logic [1:0]   occupancy;

    logic [95:0]  in_data3;
    logic [1:0]   sel3;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic [1:0]   occupancy3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_skid_stage #(.WIDTH(32), .NUM_IN(4)) dut (
        .CLK       (clk),
        .RST       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    mux_skid_stage #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .CLK       (clk),
        .RST       (rst),
        .in_data   (in_data3),
        .sel       (sel3),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy3)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [1:0]  sel;
        logic [31:0] tag;       // input k carries tag + k
        logic        out_ready;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        exp_ready;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag(input logic [31:0] tag);
        in_data = {tag + 32'd3, tag + 32'd2, tag + 32'd1, tag};
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_word;
        int          idx;
        int          rx;
        int          cyc;
        logic        acc;
        logic        pop;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 2'd0; in_data = '0;
        in_data3 = {32'hC2, 32'hC1, 32'hC0};
        sel3 = 2'd3;

        //               rst  fl  iv  sel  tag        ordy  exp_data   v  rdy occ
        vecs[0]  = '{1'b1,1'b0,1'b0,2'd0,32'h000,1'b0,32'h000,1'b0,1'b1,2'd0};
        vecs[1]  = '{1'b0,1'b0,1'b1,2'd1,32'h100,1'b0,32'h101,1'b1,1'b1,2'd1};
        vecs[2]  = '{1'b0,1'b0,1'b1,2'd3,32'h200,1'b0,32'h101,1'b1,1'b0,2'd2};
        vecs[3]  = '{1'b0,1'b0,1'b1,2'd0,32'h300,1'b0,32'h101,1'b1,1'b0,2'd2};
        vecs[4]  = '{1'b0,1'b0,1'b0,2'd0,32'h000,1'b1,32'h203,1'b1,1'b1,2'd1};
        vecs[5]  = '{1'b0,1'b0,1'b1,2'd2,32'h400,1'b1,32'h402,1'b1,1'b1,2'd1};
        vecs[6]  = '{1'b0,1'b0,1'b0,2'd0,32'h000,1'b1,32'h402,1'b0,1'b1,2'd0};
        vecs[7]  = '{1'b0,1'b0,1'b0,2'd0,32'h000,1'b1,32'h402,1'b0,1'b1,2'd0};
        vecs[8]  = '{1'b0,1'b0,1'b1,2'd0,32'h500,1'b1,32'h500,1'b1,1'b1,2'd1};
        vecs[9]  = '{1'b0,1'b1,1'b1,2'd1,32'h600,1'b0,32'h500,1'b0,1'b1,2'd0};
        vecs[10] = '{1'b0,1'b0,1'b1,2'd1,32'h700,1'b0,32'h701,1'b1,1'b1,2'd1};
        vecs[11] = '{1'b0,1'b0,1'b1,2'd2,32'h800,1'b0,32'h701,1'b1,1'b0,2'd2};
        vecs[12] = '{1'b0,1'b1,1'b1,2'd3,32'h900,1'b1,32'h701,1'b0,1'b1,2'd0};
        vecs[13] = '{1'b0,1'b0,1'b1,2'd3,32'hA00,1'b0,32'hA03,1'b1,1'b1,2'd1};
        vecs[14] = '{1'b1,1'b0,1'b1,2'd1,32'hB00,1'b1,32'h000,1'b0,1'b1,2'd0};

        for (int i = 0; i < 15; i++) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            sel       = vecs[i].sel;
            out_ready = vecs[i].out_ready;
            set_tag(vecs[i].tag);
            tick();
            check($sformatf("vec%0d out_data", i),  out_data,          vecs[i].exp_data);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid),    32'(vecs[i].exp_valid));
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),     32'(vecs[i].exp_ready));
            check($sformatf("vec%0d occupancy", i), 32'(occupancy),    32'(vecs[i].exp_occ));
        end

        // Single pulse through input 2.
        do_reset();
        check("pulse occ before", 32'(occupancy), 32'd0);
        in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pulse data",  out_data,         32'h33);
        check("pulse valid", 32'(out_valid),   32'd1);
        check("pulse occ 1", 32'(occupancy),   32'd1);
        tick();
        check("pulse valid end", 32'(out_valid), 32'd0);
        check("pulse occ end",   32'(occupancy), 32'd0);

        // Select clamp on the three-input instance (sel3 = 3 -> input 2).
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("clamp data",  out_data3,        32'hC2);
        check("clamp valid", 32'(out_valid3),  32'd1);

        // Stream 0xA0..0xA7 with out_ready low on cycles 3 and 4.
        do_reset();
        sel = 2'd0; idx = 0; rx = 0; cyc = 0;
        while (rx < 8 && cyc < 40) begin
            in_valid  = (idx < 8);
            in_data   = {4{32'hA0 + 32'(idx)}};
            out_ready = !(cyc == 3 || cyc == 4);
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            if (pop) begin
                exp_word = q.pop_front();
                check($sformatf("stream word %0d", rx), out_data, exp_word);
                rx++;
            end
            if (acc) begin
                q.push_back(32'hA0 + 32'(idx));
                idx++;
            end
            tick();
            check($sformatf("stream occ c%0d", cyc),   32'(occupancy), 32'(q.size()));
            check($sformatf("stream ready c%0d", cyc), 32'(in_ready),  32'(q.size() < 2));
            cyc++;
        end
        check("stream all received", 32'(rx), 32'd8);
        in_valid = 1'b0;

        // Flush in FULL with a concurrent word: nothing may come out after.
        do_reset();
        sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = {4{32'hD1}}; tick();
        in_data = {4{32'hD2}}; tick();
        check("flush pre occ", 32'(occupancy), 32'd2);
        flush = 1'b1; in_data = {4{32'hD3}}; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush ready", 32'(in_ready),  32'd1);
        check("flush occ",   32'(occupancy), 32'd0);
        tick();
        check("flush no leak", 32'(out_valid), 32'd0);

        // Reset while BUSY, then a normal word.
        do_reset();
        in_valid = 1'b1; in_data = {4{32'hE7}}; out_ready = 1'b0;
        tick();
        check("rst busy pre", 32'(occupancy), 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst busy valid", 32'(out_valid), 32'd0);
        check("rst busy data",  out_data,       32'h0);
        in_valid = 1'b1; in_data = {4{32'h5A}};
        tick();
        in_valid = 1'b0;
        check("after rst data",  out_data,       32'h5A);
        check("after rst valid", 32'(out_valid), 32'd1);

        // 100 cycles of simultaneous in/out from BUSY.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; in_data = {4{32'hB000_0000}};
        tick();
        for (int i = 1; i <= 100; i++) begin
            in_data = {4{32'hB000_0000 + 32'(i)}};
            tick();
            check($sformatf("thru occ %0d", i),  32'(occupancy), 32'd1);
            check($sformatf("thru data %0d", i), out_data,       32'hB000_0000 + 32'(i));
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_skid_stage
